// File: rtl/mac_unit_param.sv
// Streaming multiply-accumulate unit: TAPS signed products plus bias, optional ReLU,
// saturation to OUT_W, with valid/ready input and a backpressured output register.
module mac_unit_param #(
   parameter int DATA_W = 8,
   parameter int TAPS   = 9,
   parameter int ACC_W  = 20,
   parameter int OUT_W  = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     clear,
   input  logic                     relu_en,
   input  logic signed [ACC_W-1:0]  bias_in,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] pixel_in,
   input  logic signed [DATA_W-1:0] weight_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  result_out,
   output logic                     sat_flag,
   output logic                     busy
);

   localparam int CNT_W = $clog2(TAPS + 1);

   typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic                      relu_q, relu_d;
   logic signed [OUT_W-1:0]   res_q, res_d;
   logic                      sat_q, sat_d;
   logic                      vld_q, vld_d;

   logic signed [2*DATA_W-1:0] prod_p0;
   logic signed [ACC_W-1:0]    prod_ext_p0;
   logic signed [ACC_W-1:0]    sum_p0;
   logic signed [ACC_W-1:0]    relu_p0;
   logic [OUT_W:0]             post_p0;
   logic                       last_beat;

   function automatic logic signed [ACC_W-1:0] relu_fn(input logic en,
                                                       input logic signed [ACC_W-1:0] v);
      return (en && v[ACC_W-1]) ? '0 : v;
   endfunction

   // Returns {clipped, value}; a value fits when all bits above OUT_W-1 match its sign.
   function automatic logic [OUT_W:0] sat_fn(input logic signed [ACC_W-1:0] v);
      logic signed [OUT_W-1:0] r;
      logic                    f;
      if ((&v[ACC_W-1:OUT_W-1]) || !(|v[ACC_W-1:OUT_W-1])) begin
         r = v[OUT_W-1:0];
         f = 1'b0;
      end else if (v[ACC_W-1]) begin
         r = {1'b1, {(OUT_W-1){1'b0}}};
         f = 1'b1;
      end else begin
         r = {1'b0, {(OUT_W-1){1'b1}}};
         f = 1'b1;
      end
      return {f, r};
   endfunction

   // Stage p0: product, running sum and post-processing of the final sum
   assign prod_p0     = pixel_in * weight_in;
   assign prod_ext_p0 = ACC_W'(prod_p0);
   assign sum_p0      = acc_q + prod_ext_p0;
   assign relu_p0     = relu_fn(relu_q, sum_p0);
   assign post_p0     = sat_fn(relu_p0);
   assign last_beat   = (cnt_q == CNT_W'(TAPS - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      relu_d  = relu_q;
      res_d   = res_q;
      sat_d   = sat_q;
      vld_d   = vld_q;
      if (clear) begin
         state_d = IDLE;
         cnt_d   = '0;
         acc_d   = '0;
         vld_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  acc_d   = bias_in;
                  relu_d  = relu_en;
                  cnt_d   = '0;
                  state_d = ACCUM;
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  if (last_beat) begin
                     res_d   = post_p0[OUT_W-1:0];
                     sat_d   = post_p0[OUT_W];
                     vld_d   = 1'b1;
                     cnt_d   = '0;
                     state_d = OUTPUT;
                  end else begin
                     acc_d = sum_p0;
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            OUTPUT: begin
               if (out_ready) begin
                  vld_d   = 1'b0;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Stage p1: state and result registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         relu_q  <= 1'b0;
         res_q   <= '0;
         sat_q   <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         relu_q  <= relu_d;
         res_q   <= res_d;
         sat_q   <= sat_d;
         vld_q   <= vld_d;
      end
   end

   assign in_ready   = (state_q == ACCUM);
   assign busy       = (state_q != IDLE);
   assign out_valid  = vld_q;
   assign result_out = res_q;
   assign sat_flag   = sat_q;

endmodule

// File: tb/tb_mac_unit_param.sv
// Directed bench for mac_unit_param: a TAPS=9 instance and a TAPS=25 instance
// sharing the stream inputs, with hand-computed expected results.
module tb_mac_unit_param;

   logic               clk;
   logic               reset_n;
   logic               start9, start25;
   logic               clear;
   logic               relu_en;
   logic signed [19:0] bias9;
   logic signed [23:0] bias25;
   logic               in_valid;
   logic signed [7:0]  pixel, weight;
   logic               out_ready;

   logic               in_ready9, out_valid9, sat9, busy9;
   logic signed [15:0] res9;
   logic               in_ready25, out_valid25, sat25, busy25;
   logic signed [15:0] res25;

   int n_tests = 0;
   int n_fail  = 0;

   mac_unit_param #(.DATA_W(8), .TAPS(9), .ACC_W(20), .OUT_W(16)) u_dut9 (
      .clk(clk), .reset_n(reset_n), .start(start9), .clear(clear), .relu_en(relu_en),
      .bias_in(bias9), .in_valid(in_valid), .in_ready(in_ready9), .pixel_in(pixel),
      .weight_in(weight), .out_valid(out_valid9), .out_ready(out_ready),
      .result_out(res9), .sat_flag(sat9), .busy(busy9)
   );

   mac_unit_param #(.DATA_W(8), .TAPS(25), .ACC_W(24), .OUT_W(16)) u_dut25 (
      .clk(clk), .reset_n(reset_n), .start(start25), .clear(clear), .relu_en(relu_en),
      .bias_in(bias25), .in_valid(in_valid), .in_ready(in_ready25), .pixel_in(pixel),
      .weight_in(weight), .out_valid(out_valid25), .out_ready(out_ready),
      .result_out(res25), .sat_flag(sat25), .busy(busy25)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish (got running, want done)");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int n, input int px, input int wt, input bit gap);
      for (int i = 0; i < n; i++) begin
         if (gap) begin
            in_valid = 1'b0;
            tick();
         end
         in_valid = 1'b1;
         pixel    = 8'(px);
         weight   = 8'(wt);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic start_op9(input int b, input logic r);
      bias9   = 20'(b);
      relu_en = r;
      start9  = 1'b1;
      tick();
      start9  = 1'b0;
   endtask

   task automatic op9(input string tag, input int b, input logic r, input int px,
                      input int wt, input int exp_res, input int exp_sat);
      start_op9(b, r);
      feed(8, px, wt, 1'b0);
      chk({tag, "_ov_early"}, out_valid9, 0);
      feed(1, px, wt, 1'b0);
      chk({tag, "_ov"}, out_valid9, 1);
      chk({tag, "_res"}, res9, exp_res);
      chk({tag, "_sat"}, sat9, exp_sat);
      chk({tag, "_inrdy"}, in_ready9, 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_ov_drop"}, out_valid9, 0);
      chk({tag, "_idle"}, busy9, 0);
   endtask

   initial begin
      reset_n   = 1'b0;
      start9    = 1'b0;
      start25   = 1'b0;
      clear     = 1'b0;
      relu_en   = 1'b0;
      bias9     = '0;
      bias25    = '0;
      in_valid  = 1'b0;
      pixel     = '0;
      weight    = '0;
      out_ready = 1'b0;
      tick();
      tick();
      chk("rst_ov", out_valid9, 0);
      chk("rst_inrdy", in_ready9, 0);
      chk("rst_busy", busy9, 0);
      chk("rst_sat", sat9, 0);
      chk("rst_res", res9, 0);
      reset_n = 1'b1;
      tick();

      op9("basic", 0, 1'b0, 1, 2, 18, 0);
      op9("satpos", 0, 1'b0, -128, -128, 32767, 1);
      op9("satneg", 0, 1'b0, -128, 127, -32768, 1);
      op9("relu_on", 5, 1'b1, 10, -3, 0, 0);
      op9("relu_off", 5, 1'b0, 10, -3, -265, 0);

      // Gapped input, held output under backpressure, start ignored in OUTPUT
      start_op9(100, 1'b0);
      chk("gap_inrdy", in_ready9, 1);
      feed(9, 7, -5, 1'b1);
      chk("gap_ov", out_valid9, 1);
      for (int i = 0; i < 3; i++) begin
         start9 = (i == 1);
         tick();
         chk("hold_ov", out_valid9, 1);
         chk("hold_res", res9, -215);
         chk("hold_busy", busy9, 1);
      end
      start9    = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("after_hold_ov", out_valid9, 0);
      chk("after_hold_busy", busy9, 0);
      tick();
      chk("start_ignored", busy9, 0);

      // Asynchronous reset after 4 beats
      start_op9(0, 1'b0);
      feed(4, 3, 3, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_busy", busy9, 0);
      chk("arst_inrdy", in_ready9, 0);
      chk("arst_ov", out_valid9, 0);
      chk("arst_res", res9, 0);
      chk("arst_sat", sat9, 0);
      tick();
      reset_n = 1'b1;
      tick();
      op9("post_rst", 0, 1'b0, 3, 3, 81, 0);

      // Clear after 5 beats, with a beat offered in the clear cycle
      start_op9(0, 1'b0);
      feed(5, 4, 4, 1'b0);
      clear    = 1'b1;
      in_valid = 1'b1;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      chk("clr_busy", busy9, 0);
      chk("clr_ov", out_valid9, 0);
      chk("clr_res_kept", res9, 81);
      feed(4, 4, 4, 1'b0);
      chk("clr_no_ov", out_valid9, 0);
      op9("post_clr", 0, 1'b0, 1, 1, 9, 0);

      // TAPS=25 instance
      bias25  = -24'sd5;
      relu_en = 1'b0;
      start25 = 1'b1;
      tick();
      start25 = 1'b0;
      feed(24, 1, 1, 1'b0);
      chk("t25_ov_early", out_valid25, 0);
      feed(1, 1, 1, 1'b0);
      chk("t25_ov", out_valid25, 1);
      chk("t25_res", res25, 20);
      chk("t25_sat", sat25, 0);
      chk("t25_dut9_idle", busy9, 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t25_idle", busy25, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
